// File: rtl/decode_pkg.sv
// decode_pkg: shared widths and constants for the decode stage and its
// register file. The field map is fixed MIPS-style: opcode at the top,
// then rs, rt, rd, with funct and the immediate in the low bits.
package decode_pkg;
  localparam int IWIDTH       = 32;
  localparam int DWIDTH       = 32;
  localparam int AWIDTH       = 5;
  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;
  localparam int IMM_WIDTH    = 16;
  localparam int NREGS        = 32;

  // Opcode 0 selects R-type: rd comes from the rd field and funct is live.
  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = '0;

  function automatic logic is_rtype(input logic [OPCODE_WIDTH-1:0] op);
    return op == OP_RTYPE;
  endfunction
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 32-entry register file with two combinational read ports
// and one synchronous write port. Register 0 reads as zero and drops writes.
// A write landing on the same edge as a read is forwarded to the read port,
// so a consumer registering the read data sees the new value.
// Ports:
//   clk, rst        clock, synchronous active-low reset (clears all entries)
//   wr, addr_wr,
//   data_wr         write port
//   addr_rs/rt      read addresses
//   data_rs/rt      read data (with write-through forwarding)
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DWIDTH = decode_pkg::DWIDTH,
  parameter int AWIDTH = decode_pkg::AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr_wr,
  input  logic [DWIDTH-1:0] data_wr,
  input  logic [AWIDTH-1:0] addr_rs,
  input  logic [AWIDTH-1:0] addr_rt,
  output logic [DWIDTH-1:0] data_rs,
  output logic [DWIDTH-1:0] data_rt
);
  logic [NREGS-1:0][DWIDTH-1:0] mem;
  logic                         we;

  assign we = wr && (addr_wr != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
    end else if (we) begin
      mem[addr_wr] <= data_wr;
    end
  end

  function automatic logic [DWIDTH-1:0] rd_port(input logic [AWIDTH-1:0] a);
    if (a == '0)                  return '0;
    else if (we && addr_wr == a)  return data_wr;
    else                          return mem[a];
  endfunction

  assign data_rs = rd_port(addr_rs);
  assign data_rt = rd_port(addr_rt);
endmodule

// File: rtl/decode.sv
// decode: instruction decode stage. Splits the instruction into its fields,
// reads rs/rt from the register file, and registers everything with one
// cycle of latency. When the stage enable is low the decoded outputs hold
// and the output valid drops. Writeback into the register file is
// independent of the stage enable.
// Ports:
//   d_clk, d_rst                 clock, synchronous active-low reset
//   d_i_ce, d_i_instr            instruction valid and word
//   d_i_wr_reg, d_i_addr_wr,
//   d_i_data_rd                  writeback port
//   d_o_opcode, d_o_funct        decoded opcode / funct (funct 0 for non R-type)
//   d_o_addr_rs/rt/rd            register addresses (rd = rt for non R-type)
//   d_o_data_rs/rt               register read data
//   d_o_imm                      raw immediate
//   d_o_ce                       output valid (d_i_ce delayed one cycle)
module decode
  import decode_pkg::*;
#(
  parameter int IWIDTH       = decode_pkg::IWIDTH,
  parameter int DWIDTH       = decode_pkg::DWIDTH,
  parameter int AWIDTH       = decode_pkg::AWIDTH,
  parameter int OPCODE_WIDTH = decode_pkg::OPCODE_WIDTH,
  parameter int FUNCT_WIDTH  = decode_pkg::FUNCT_WIDTH,
  parameter int IMM_WIDTH    = decode_pkg::IMM_WIDTH
) (
  input  logic                    d_clk,
  input  logic                    d_rst,
  input  logic                    d_i_ce,
  input  logic [IWIDTH-1:0]       d_i_instr,
  input  logic                    d_i_wr_reg,
  input  logic [AWIDTH-1:0]       d_i_addr_wr,
  input  logic [DWIDTH-1:0]       d_i_data_rd,
  output logic [OPCODE_WIDTH-1:0] d_o_opcode,
  output logic [FUNCT_WIDTH-1:0]  d_o_funct,
  output logic [AWIDTH-1:0]       d_o_addr_rs,
  output logic [AWIDTH-1:0]       d_o_addr_rt,
  output logic [AWIDTH-1:0]       d_o_addr_rd,
  output logic [DWIDTH-1:0]       d_o_data_rs,
  output logic [DWIDTH-1:0]       d_o_data_rt,
  output logic [IMM_WIDTH-1:0]    d_o_imm,
  output logic                    d_o_ce
);
  // Field positions, counted down from the top of the word.
  localparam int RS_MSB = IWIDTH - OPCODE_WIDTH - 1;
  localparam int RT_MSB = RS_MSB - AWIDTH;
  localparam int RD_MSB = RT_MSB - AWIDTH;
  localparam int SH_MSB = RD_MSB - AWIDTH;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [AWIDTH-1:0]       rs, rt, rd_fld;
  logic [FUNCT_WIDTH-1:0]  funct_fld;
  logic [IMM_WIDTH-1:0]    imm;
  logic [DWIDTH-1:0]       data_rs, data_rt;
  logic                    rtype;
  logic                    unused_shamt;

  assign opcode    = d_i_instr[IWIDTH-1 -: OPCODE_WIDTH];
  assign rs        = d_i_instr[RS_MSB -: AWIDTH];
  assign rt        = d_i_instr[RT_MSB -: AWIDTH];
  assign rd_fld    = d_i_instr[RD_MSB -: AWIDTH];
  assign funct_fld = d_i_instr[FUNCT_WIDTH-1:0];
  assign imm       = d_i_instr[IMM_WIDTH-1:0];
  assign rtype     = is_rtype(opcode);

  // Shift-amount bits are not decoded by this stage.
  assign unused_shamt = ^d_i_instr[SH_MSB:FUNCT_WIDTH];

  decode_regfile #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_regfile (
    .clk     (d_clk),
    .rst     (d_rst),
    .wr      (d_i_wr_reg),
    .addr_wr (d_i_addr_wr),
    .data_wr (d_i_data_rd),
    .addr_rs (rs),
    .addr_rt (rt),
    .data_rs (data_rs),
    .data_rt (data_rt)
  );

  always_ff @(posedge d_clk) begin
    if (!d_rst) begin
      d_o_opcode  <= '0;
      d_o_funct   <= '0;
      d_o_addr_rs <= '0;
      d_o_addr_rt <= '0;
      d_o_addr_rd <= '0;
      d_o_data_rs <= '0;
      d_o_data_rt <= '0;
      d_o_imm     <= '0;
      d_o_ce      <= 1'b0;
    end else begin
      d_o_ce <= d_i_ce;
      if (d_i_ce) begin
        d_o_opcode  <= opcode;
        d_o_funct   <= rtype ? funct_fld : '0;
        d_o_addr_rs <= rs;
        d_o_addr_rt <= rt;
        d_o_addr_rd <= rtype ? rd_fld : rt;
        d_o_data_rs <= data_rs;
        d_o_data_rt <= data_rt;
        d_o_imm     <= imm;
      end
    end
  end
endmodule

// File: tb/tb_decode.sv
module tb_decode;
  logic        d_clk = 1'b0;
  logic        d_rst = 1'b0;
  logic        d_i_ce = 1'b0;
  logic [31:0] d_i_instr = '0;
  logic        d_i_wr_reg = 1'b0;
  logic [4:0]  d_i_addr_wr = '0;
  logic [31:0] d_i_data_rd = '0;
  logic [5:0]  d_o_opcode, d_o_funct;
  logic [4:0]  d_o_addr_rs, d_o_addr_rt, d_o_addr_rd;
  logic [31:0] d_o_data_rs, d_o_data_rt;
  logic [15:0] d_o_imm;
  logic        d_o_ce;

  always #5 d_clk = ~d_clk;

  decode dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(d_i_ce), .d_i_instr(d_i_instr),
    .d_i_wr_reg(d_i_wr_reg), .d_i_addr_wr(d_i_addr_wr), .d_i_data_rd(d_i_data_rd),
    .d_o_opcode(d_o_opcode), .d_o_funct(d_o_funct), .d_o_addr_rs(d_o_addr_rs),
    .d_o_addr_rt(d_o_addr_rt), .d_o_addr_rd(d_o_addr_rd), .d_o_data_rs(d_o_data_rs),
    .d_o_data_rt(d_o_data_rt), .d_o_imm(d_o_imm), .d_o_ce(d_o_ce)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: register contents plus the expected visible outputs.
  int unsigned rf[32];
  int unsigned e_op, e_fn, e_rs, e_rt, e_rd, e_drs, e_drt, e_imm, e_ce;

  function automatic int unsigned model_read(input int unsigned a, input bit wr,
                                             input int unsigned wa, input int unsigned wd);
    if (a == 0) return 0;
    if (wr && wa == a) return wd;
    return rf[a];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_op"},  32'(d_o_opcode),  e_op);
    chk({tag, "_fn"},  32'(d_o_funct),   e_fn);
    chk({tag, "_rs"},  32'(d_o_addr_rs), e_rs);
    chk({tag, "_rt"},  32'(d_o_addr_rt), e_rt);
    chk({tag, "_rd"},  32'(d_o_addr_rd), e_rd);
    chk({tag, "_drs"}, d_o_data_rs,      e_drs);
    chk({tag, "_drt"}, d_o_data_rt,      e_drt);
    chk({tag, "_imm"}, 32'(d_o_imm),     e_imm);
    chk({tag, "_ce"},  32'(d_o_ce),      e_ce);
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic step(input string tag, input bit rst_n, input bit ce,
                      input logic [31:0] instr, input bit wr,
                      input logic [4:0] wa, input logic [31:0] wd);
    int unsigned iw, op, rs, rt;
    @(negedge d_clk);
    d_rst = rst_n; d_i_ce = ce; d_i_instr = instr;
    d_i_wr_reg = wr; d_i_addr_wr = wa; d_i_data_rd = wd;
    iw = instr;
    if (!rst_n) begin
      {e_op, e_fn, e_rs, e_rt, e_rd, e_drs, e_drt, e_imm, e_ce} = '0;
      foreach (rf[i]) rf[i] = 0;
    end else begin
      e_ce = ce;
      if (ce) begin
        op    = iw / (1 << 26);
        rs    = (iw / (1 << 21)) % 32;
        rt    = (iw / (1 << 16)) % 32;
        e_op  = op;
        e_rs  = rs;
        e_rt  = rt;
        e_imm = iw % 65536;
        e_rd  = (op == 0) ? (iw / (1 << 11)) % 32 : rt;
        e_fn  = (op == 0) ? iw % 64 : 0;
        e_drs = model_read(rs, wr, wa, wd);
        e_drt = model_read(rt, wr, wa, wd);
      end
      if (wr && wa != 0) rf[wa] = wd;
    end
    @(posedge d_clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] instr, wd;
    logic [4:0]  wa;
    bit          ce, wr, rn;

    foreach (rf[i]) rf[i] = 0;
    {e_op, e_fn, e_rs, e_rt, e_rd, e_drs, e_drt, e_imm, e_ce} = '0;

    step("rst0", 0, 1, 32'hFFFF_FFFF, 1, 5'd7, 32'h1111_1111);
    step("rst1", 0, 0, 32'h0, 0, 5'd0, 32'h0);

    step("add", 1, 1, 32'h0043_0820, 0, 5'd0, 32'h0);
    chk("add_rd_lit", 32'(d_o_addr_rd), 1);
    chk("add_fn_lit", 32'(d_o_funct), 32'h20);
    chk("add_imm_lit", 32'(d_o_imm), 32'h0820);
    step("sub", 1, 1, 32'h016C_5023, 0, 5'd0, 32'h0);
    chk("sub_rd_lit", 32'(d_o_addr_rd), 10);
    step("and", 1, 1, 32'h01CF_6824, 0, 5'd0, 32'h0);
    chk("and_fn_lit", 32'(d_o_funct), 32'h24);
    step("beq", 1, 1, 32'h1041_0064, 0, 5'd0, 32'h0);
    chk("beq_op_lit", 32'(d_o_opcode), 4);
    chk("beq_rd_lit", 32'(d_o_addr_rd), 1);
    chk("beq_fn_lit", 32'(d_o_funct), 0);

    step("wr2", 1, 0, 32'h0, 1, 5'd2, 32'hDEAD_BEEF);
    step("rd2", 1, 1, 32'h0043_0820, 0, 5'd0, 32'h0);
    chk("rd2_drs_lit", d_o_data_rs, 32'hDEAD_BEEF);
    chk("rd2_drt_lit", d_o_data_rt, 32'h0);
    step("byp3", 1, 1, 32'h0043_0820, 1, 5'd3, 32'h1234_5678);
    chk("byp3_drt_lit", d_o_data_rt, 32'h1234_5678);

    step("wr0", 1, 0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
    step("rd0", 1, 1, 32'h0000_0820, 0, 5'd0, 32'h0);
    chk("rd0_drs_lit", d_o_data_rs, 32'h0);
    step("byp0", 1, 1, 32'h0003_0820, 1, 5'd0, 32'hAAAA_5555);
    step("hold", 1, 0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0);
    chk("hold_ce_lit", 32'(d_o_ce), 0);
    chk("hold_drt_lit", d_o_data_rt, 32'h1234_5678);

    step("midrst", 0, 1, 32'h0043_0820, 1, 5'd4, 32'h5555_5555);
    step("postrst", 1, 1, 32'h0043_0820, 0, 5'd0, 32'h0);
    chk("postrst_drs_lit", d_o_data_rs, 32'h0);

    for (int n = 0; n < 400; n++) begin
      rn    = ($urandom_range(0, 49) != 0);
      ce    = ($urandom_range(0, 3) != 0);
      wr    = $urandom_range(0, 1);
      wa    = 5'($urandom_range(0, 31));
      wd    = $urandom;
      instr = $urandom;
      if ($urandom_range(0, 1)) instr[31:26] = 6'd0;
      if ($urandom_range(0, 3) == 0) instr[25:21] = wa;
      if ($urandom_range(0, 3) == 0) instr[20:16] = wa;
      step("rnd", rn, ce, instr, wr, wa, wd);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
